// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the MiniRiscV run-control logic: FSM encodings,
// synchroniser depth and default reset-sequencing timings.
package cpu_ctrl_pkg;

   localparam logic [2:0] S_RESET = 3'd0;
   localparam logic [2:0] S_HOLD  = 3'd1;
   localparam logic [2:0] S_REL   = 3'd2;
   localparam logic [2:0] S_RUN   = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam int SYNC_STAGES  = 2;
   localparam int RST_HOLD_DEF = 4;
   localparam int STAGGER_DEF  = 2;

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously with rst, deasserts only after
// the release has travelled through STAGES flops on clk_hw.
module rst_sync
   import cpu_ctrl_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES
) (
   input  logic clk_hw,
   input  logic rst,
   output logic released
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk_hw or negedge rst) begin
      if (!rst) chain <= '0;
      else      chain <= {chain[STAGES-2:0], 1'b1};
   end

   assign released = chain[STAGES-1];

endmodule

// File: rtl/clk_rst_seq_ctrl.sv
// Run-control for the core: reset hold, staggered domain release, cpu_en gating
// and a saturating cycle counter. Define RUN_LIMIT_EN to stop after MAX_CYCLES.
module clk_rst_seq_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int          NUM_DOM    = 3,
   parameter int          RST_HOLD   = RST_HOLD_DEF,
   parameter int          STAGGER    = STAGGER_DEF,
   parameter int          CNT_W      = 32,
   parameter int unsigned MAX_CYCLES = 250
) (
   input  logic               clk_hw,
   input  logic               rst,
   input  logic               step_mode,
   input  logic               step_req,
   input  logic               halt_req,
   input  logic               resume,
   output logic [NUM_DOM-1:0] dom_rst_n,
   output logic               cpu_en,
   output logic [CNT_W-1:0]   cycle_cnt,
   output logic [2:0]         state,
   output logic               done
);

   localparam int TW = $clog2(((RST_HOLD > STAGGER) ? RST_HOLD : STAGGER) + 1);
   localparam int IW = $clog2(NUM_DOM + 1);
   localparam logic [TW-1:0] HOLD_LOAD = TW'(RST_HOLD - 1);
   localparam logic [TW-1:0] STAG_LOAD = TW'(STAGGER - 1);

   logic             released;
   logic [TW-1:0]    timer;
   logic [IW-1:0]    dom_idx;
   logic             step_grant;
   logic             limit_hit;
   logic [CNT_W-1:0] cnt_next;

   rst_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
      .clk_hw   (clk_hw),
      .rst      (rst),
      .released (released)
   );

   // halt_req gates the enable combinationally so the halting cycle never executes
   assign cpu_en   = (state == S_RUN) && !halt_req && (step_mode ? step_grant : 1'b1);
   assign cnt_next = (cycle_cnt == '1) ? cycle_cnt : cycle_cnt + CNT_W'(1);

`ifdef RUN_LIMIT_EN
   // A budget wider than the counter can never be reached
   localparam bit LIMIT_FITS = (CNT_W >= 32) || ((MAX_CYCLES >> CNT_W) == 0);
   assign limit_hit = LIMIT_FITS && cpu_en && (cnt_next == CNT_W'(MAX_CYCLES));
   assign done      = (state == S_DONE);
`else
   assign limit_hit = 1'b0;
   assign done      = 1'b0;
`endif

   always_ff @(posedge clk_hw or negedge rst) begin
      if (!rst) begin
         state      <= S_RESET;
         timer      <= '0;
         dom_idx    <= '0;
         dom_rst_n  <= '0;
         step_grant <= 1'b0;
         cycle_cnt  <= '0;
      end else begin
         // A request during an active grant is dropped, never queued
         step_grant <= (state == S_RUN) && step_mode && step_req && !halt_req && !step_grant;
         if (cpu_en) cycle_cnt <= cnt_next;
         case (state)
            S_RESET: begin
               if (released) begin
                  state <= S_HOLD;
                  timer <= HOLD_LOAD;
               end
            end
            S_HOLD: begin
               if (timer != '0) begin
                  timer <= timer - TW'(1);
               end else begin
                  state        <= S_REL;
                  dom_rst_n[0] <= 1'b1;
                  dom_idx      <= IW'(1);
                  timer        <= STAG_LOAD;
               end
            end
            S_REL: begin
               if (timer != '0) begin
                  timer <= timer - TW'(1);
               end else if (dom_idx == IW'(NUM_DOM)) begin
                  state <= S_RUN;
               end else begin
                  dom_rst_n <= dom_rst_n | (NUM_DOM'(1) << dom_idx);
                  dom_idx   <= dom_idx + IW'(1);
                  timer     <= STAG_LOAD;
               end
            end
            S_RUN: begin
               if (halt_req)       state <= S_HALT;
               else if (limit_hit) state <= S_DONE;
            end
            S_HALT: begin
               if (resume && !halt_req) state <= S_RUN;
            end
            S_DONE: begin
               state <= S_DONE;
            end
            default: state <= S_RESET;
         endcase
      end
   end

endmodule
